slice_streamer: RTL and testbench
=================================

Name: slice_streamer

Overview:
- Sequential consumer of indexed up part-selects (`data[ptr+:W]`).
- Accepts one wide word, declared as `[MSB:LSB]` (either endianness, negative bounds allowed), over a valid/ready input.
- Emits successive W-bit windows on a valid/ready output, stepping the base index by STEP.
- Serves as the clocked neighbour for part-select frontend tests: its output is checked against `data[ptr+:W]` semantics.

Parameters:
- MSB, 0: left bound of the input word declaration.
- LSB, 0: right bound of the input word declaration. Big-endian when MSB < LSB.
- W, 2: window width. Must satisfy 1 <= W <= N, where N = |MSB-LSB|+1.
- STEP, W: base-index increment per beat. Must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word offered.
- in_ready  output  1  block can accept a word.
- in_data  input  [MSB:LSB]  word to stream.
- out_valid  output  1  window valid.
- out_ready  input  1  consumer accepts window.
- out_data  output  [W-1:0]  equals `data_q[ptr+:W]`.
- out_last  output  1  final window of the current word.
- out_idx  output  32 (signed)  current ptr.

Behaviour:
- Definitions: LO = min(MSB,LSB), HI = max(MSB,LSB). data_q is declared `[MSB:LSB]`, the same direction as in_data.
- Reset (async, any time including mid-stream):
  - state=IDLE, data_q=0, ptr=LO.
  - out_valid=0, out_last=0, out_data=0, out_idx=LO, in_ready=1.
- States: IDLE, STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: data_q<=in_data, ptr<=LO, go to STREAM.
  - out_valid rises on the next cycle (latency 1).
- STREAM:
  - out_valid=1; out_data = `data_q[ptr+:W]` (bit order follows the declaration direction, exactly as LRM indexed part-select).
  - out_last=1 when ptr+STEP+W-1 > HI.
  - Beat transfers on out_valid&&out_ready. Non-last beat: ptr<=ptr+STEP.
  - out_ready=0: out_data, out_idx and out_last hold stable indefinitely.
- Back-to-back:
  - in_ready = IDLE || (STREAM && out_ready && out_last).
  - Last beat and in_valid in the same cycle: load the new word, ptr<=LO, stay in STREAM. No bubble.
  - Last beat without in_valid: go to IDLE.
- Arithmetic:
  - ptr is a 32-bit signed integer; all bound comparisons are signed.
  - Bits above the last fully in-range window are not emitted (default build).
- in_data is sampled only on an accepted transfer; changes at other times are ignored.

Optional Feature:
- Macro: SLICE_STREAMER_XPAD_EN.
- Defined:
  - Streaming continues while ptr <= HI.
  - out_last=1 when ptr+STEP > HI.
  - Window bits whose index exceeds HI read 1'bx, matching part-select out-of-range semantics.
- Undefined: behaviour as above; no x is ever driven on out_data.

Decomposition:
- Package slice_streamer_pkg holds:
  - typedef enum logic {IDLE, STREAM} state_t.
  - Constant-function helpers lo_of(MSB,LSB) and hi_of(MSB,LSB).
- No sub-module needed. Window extraction is a single continuous part-select kept in the top module so the frontend's `+:` lowering is exercised directly.

Test Plan:
- Little-endian. MSB=6, LSB=0, W=2, STEP=2; in_data=7'b1011001; out_ready=1.
  - Expect 3 beats: 01 (idx 0), 10 (idx 2), 01 (idx 4, last=1).
  - Then IDLE.
- Big-endian. MSB=0, LSB=6, W=2, STEP=2; same bits (data[0]=1 ... data[6]=1).
  - Expect 10 (idx 0), 11 (idx 2), 00 (idx 4, last).
- Negative bounds. MSB=4, LSB=-2, W=3, STEP=3; in_data=7'b1110010.
  - Expect 010 (idx -2), 110 (idx 1, last).
- Back-pressure and back-to-back. Setup as in the little-endian case:
  - Hold out_ready=0 for 3 cycles at idx 2: out_data=10 stays stable.
  - Assert in_valid with a new word during the last beat: next cycle shows idx 0 of the new word, no idle cycle.
- Reset and XPAD.
  - Assert rst mid-stream at idx 2: immediately out_valid=0, in_ready=1, out_idx=0.
  - With SLICE_STREAMER_XPAD_EN, little-endian setup: a 4th beat at idx 6 gives out_data=2'bx1 with last=1; compare with ===.

Source files
------------

// File: rtl/slice_streamer_pkg.sv
// rtl/slice_streamer_pkg.sv - shared state type and bound helpers for slice_streamer
package slice_streamer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int lo_of(input int msb, input int lsb);
    return (msb < lsb) ? msb : lsb;
  endfunction

  function automatic int hi_of(input int msb, input int lsb);
    return (msb < lsb) ? lsb : msb;
  endfunction

endpackage

// File: rtl/slice_streamer.sv
// rtl/slice_streamer.sv - streams successive data_q[ptr+:W] windows of one [MSB:LSB] word
// Optional SLICE_STREAMER_XPAD_EN: keep streaming while ptr <= HI; bits above HI read x.
module slice_streamer
  import slice_streamer_pkg::*;
#(
  parameter int MSB  = 0,
  parameter int LSB  = 0,
  parameter int W    = 2,
  parameter int STEP = W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MSB:LSB]     in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic               out_last,
  output logic signed [31:0] out_idx
);

  localparam int LO = lo_of(MSB, LSB);
  localparam int HI = hi_of(MSB, LSB);

  state_t             state_q, state_d;
  logic [MSB:LSB]     data_q, data_d;
  logic signed [31:0] ptr_q, ptr_d;
  logic               streaming;
  logic               at_last;
  logic               beat_done;

  assign streaming = (state_q == STREAM);

`ifdef SLICE_STREAMER_XPAD_EN
  assign at_last = (ptr_q + STEP > HI);
`else
  assign at_last = (ptr_q + STEP + W - 1 > HI);
`endif

  assign beat_done = streaming && out_ready;

  // Window extraction stays a single indexed part-select so bit order follows the declaration.
  assign out_data  = data_q[ptr_q +: W];
  assign out_valid = streaming;
  assign out_last  = streaming && at_last;
  assign out_idx   = ptr_q;
  assign in_ready  = (state_q == IDLE) || (beat_done && at_last);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          ptr_d   = LO;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (beat_done) begin
          if (!at_last) begin
            ptr_d = ptr_q + STEP;
          end else if (in_valid) begin
            data_d = in_data;
            ptr_d  = LO;
          end else begin
            ptr_d   = LO;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = LO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      ptr_q   <= LO;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_slice_streamer.sv
// tb/tb_slice_streamer.sv - checks slice_streamer in LE, BE and negative-bound configurations
module tb_slice_streamer;

  logic clk = 1'b0;
  logic rst;
  logic              in_valid  [3];
  logic              out_ready [3];
  logic [6:0]        in_data   [3];
  logic              in_ready  [3];
  logic              out_valid [3];
  logic              out_last  [3];
  logic signed [31:0] out_idx  [3];
  logic [2:0]        od        [3];
  logic [1:0]        od0, od1;
  logic [2:0]        od2;
  int checks = 0;
  int errors = 0;

  assign od[0] = {1'b0, od0};
  assign od[1] = {1'b0, od1};
  assign od[2] = od2;

  always #5 clk = ~clk;

  slice_streamer #(.MSB(6), .LSB(0), .W(2), .STEP(2)) u_le (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od0), .out_last(out_last[0]),
    .out_idx(out_idx[0]));

  slice_streamer #(.MSB(0), .LSB(6), .W(2), .STEP(2)) u_be (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od1), .out_last(out_last[1]),
    .out_idx(out_idx[1]));

  slice_streamer #(.MSB(4), .LSB(-2), .W(3), .STEP(3)) u_neg (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od2), .out_last(out_last[2]),
    .out_idx(out_idx[2]));

  function automatic int c_msb(input int d);
    case (d) 0: return 6; 1: return 0; default: return 4; endcase
  endfunction

  function automatic int c_lsb(input int d);
    case (d) 0: return 0; 1: return 6; default: return -2; endcase
  endfunction

  function automatic int c_w(input int d);
    return (d == 2) ? 3 : 2;
  endfunction

  function automatic int c_lo(input int d);
    return (c_msb(d) < c_lsb(d)) ? c_msb(d) : c_lsb(d);
  endfunction

  function automatic int c_hi(input int d);
    return (c_msb(d) < c_lsb(d)) ? c_lsb(d) : c_msb(d);
  endfunction

  // Element j of the declared word; the literal's leftmost bit is element MSB.
  function automatic logic ref_bit(input int d, input logic [6:0] v, input int j);
    int pos;
    if (j < c_lo(d) || j > c_hi(d)) return 1'bx;
    pos = (c_msb(d) >= c_lsb(d)) ? c_msb(d) - j : j - c_msb(d);
    return v[6 - pos];
  endfunction

  function automatic logic [2:0] ref_win(input int d, input logic [6:0] v, input int p);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < c_w(d); k++)
      r[k] = (c_msb(d) >= c_lsb(d)) ? ref_bit(d, v, p + k) : ref_bit(d, v, p + c_w(d) - 1 - k);
    return r;
  endfunction

  function automatic int n_beats(input int d);
    int n = 0;
`ifdef SLICE_STREAMER_XPAD_EN
    for (int p = c_lo(d); p <= c_hi(d); p += c_w(d)) n++;
`else
    for (int p = c_lo(d); p + c_w(d) - 1 <= c_hi(d); p += c_w(d)) n++;
`endif
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int d, input logic [6:0] w);
    in_valid[d] = 1'b1;
    in_data[d]  = w;
    @(negedge clk);
    check("load_in_ready", in_ready[d], 1);
    check("load_idle", out_valid[d], 0);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_data[d]  = 7'($urandom);
  endtask

  task automatic expect_beat(input int d, input logic [2:0] data, input int idx, input bit last);
    out_ready[d] = 1'b1;
    @(negedge clk);
    check("dir_valid", out_valid[d], 1);
    check("dir_data", od[d], data);
    check("dir_idx", out_idx[d], idx);
    check("dir_last", out_last[d], last);
    @(posedge clk); #1;
  endtask

  task automatic expect_idle(input int d);
    @(negedge clk);
    check("idle_valid", out_valid[d], 0);
    check("idle_in_ready", in_ready[d], 1);
    @(posedge clk); #1;
  endtask

  task automatic stream(input int d, input logic [6:0] w, input bit chain,
                        input logic [6:0] nxt, input bit stall);
    int n;
    int stalls;
    int p;
    n = n_beats(d);
    for (int b = 0; b < n; b++) begin
      p = c_lo(d) + b * c_w(d);
      stalls = stall ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s <= stalls; s++) begin
        out_ready[d] = (s == stalls);
        if (b == n - 1 && chain) begin
          in_valid[d] = 1'b1;
          in_data[d]  = nxt;
        end
        @(negedge clk);
        check("valid", out_valid[d], 1);
        check("data", od[d], ref_win(d, w, p));
        check("idx", out_idx[d], p);
        check("last", out_last[d], b == n - 1);
        check("in_ready", in_ready[d], (b == n - 1) && (s == stalls));
        @(posedge clk); #1;
      end
    end
    in_valid[d]  = 1'b0;
    in_data[d]   = 7'($urandom);
    out_ready[d] = 1'($urandom);
    if (!chain) expect_idle(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] w;
    logic [6:0] nxt;
    bit ch;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      in_data[d]   = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_valid", out_valid[d], 0);
      check("rst_in_ready", in_ready[d], 1);
      check("rst_idx", out_idx[d], c_lo(d));
      check("rst_data", od[d], 0);
      check("rst_last", out_last[d], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

`ifndef SLICE_STREAMER_XPAD_EN
    load(0, 7'b1011001);
    expect_beat(0, 3'b001, 0, 0);
    expect_beat(0, 3'b010, 2, 0);
    expect_beat(0, 3'b001, 4, 1);
    expect_idle(0);

    load(1, 7'b1011001);
    expect_beat(1, 3'b010, 0, 0);
    expect_beat(1, 3'b011, 2, 0);
    expect_beat(1, 3'b000, 4, 1);
    expect_idle(1);

    load(2, 7'b1110010);
    expect_beat(2, 3'b010, -2, 0);
    expect_beat(2, 3'b110, 1, 1);
    expect_idle(2);
`endif

    // Back-pressure at idx 2, then a new word offered during the final beat.
    load(0, 7'b1011001);
    expect_beat(0, 3'b001, 0, 0);
    out_ready[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_data", od[0], 3'b010);
      check("bp_hold_idx", out_idx[0], 2);
      check("bp_hold_last", out_last[0], 0);
      @(posedge clk); #1;
    end
    expect_beat(0, 3'b010, 2, 0);
`ifdef SLICE_STREAMER_XPAD_EN
    expect_beat(0, 3'b001, 4, 0);
    in_valid[0] = 1'b1;
    in_data[0]  = 7'b0100111;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("xpad_data", od[0], 3'b0x1);
    check("xpad_idx", out_idx[0], 6);
    check("xpad_last", out_last[0], 1);
`else
    in_valid[0] = 1'b1;
    in_data[0]  = 7'b0100111;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("b2b_last_data", od[0], 3'b001);
    check("b2b_last_idx", out_idx[0], 4);
    check("b2b_last", out_last[0], 1);
`endif
    check("b2b_in_ready", in_ready[0], 1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    in_data[0]  = 7'($urandom);
    stream(0, 7'b0100111, 0, 7'd0, 0);

    // Asynchronous reset while sitting at idx 2.
    load(0, 7'b1011001);
    expect_beat(0, 3'b001, 0, 0);
    out_ready[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid[0], 0);
    check("mid_rst_in_ready", in_ready[0], 1);
    check("mid_rst_idx", out_idx[0], 0);
    check("mid_rst_data", od[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int d = 0; d < 3; d++) begin
      w = 7'($urandom);
      load(d, w);
      for (int i = 0; i < 12; i++) begin
        nxt = 7'($urandom);
        ch  = (i < 11) && ($urandom_range(0, 1) == 1);
        stream(d, w, ch, nxt, 1);
        if (!ch && i < 11) load(d, nxt);
        w = nxt;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
